// File: rtl/mem_access_unit.sv
// RV32 data-memory access stage: issues a req/ack transaction for the load or store in EX/MEM,
// steers byte lanes, formats load results and stalls or halts the pipeline around the access.
module mem_access_unit #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_memRead,
  input  logic        ex_memWrite,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_storeData,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic [31:0] readData,
  output logic        mem_stall,
  output logic        mem_fault,
  output logic [1:0]  fault_code,
  output logic [31:0] fault_addr
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE, FAULT} state_t;

  localparam logic [7:0] LAST_WAIT = 8'(MEM_TIMEOUT - 1);

  state_t      state_reg;
  logic [7:0]  count_reg;
  logic [2:0]  funct3_reg;
  logic [1:0]  lane_reg;
  logic        load_reg;

  logic        access;
  logic        load_ok;
  logic        store_ok;
  logic        op_illegal;
  logic        misaligned;
  logic [31:0] wdata_fmt;
  logic [3:0]  wstrb_fmt;
  logic [7:0]  rbyte [4];
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] load_fmt;

  assign access     = ex_valid & (ex_memRead | ex_memWrite);
  assign load_ok    = (ex_funct3 == 3'b000) | (ex_funct3 == 3'b001) | (ex_funct3 == 3'b010) |
                      (ex_funct3 == 3'b100) | (ex_funct3 == 3'b101);
  assign store_ok   = ~ex_funct3[2] & (ex_funct3[1:0] != 2'b11);
  assign op_illegal = (ex_memRead & ex_memWrite) | (ex_memRead & ~load_ok) |
                      (ex_memWrite & ~store_ok);
  assign misaligned = ((ex_funct3[1:0] == 2'b01) & ex_addr[0]) |
                      ((ex_funct3[1:0] == 2'b10) & (ex_addr[1:0] != 2'b00));

  assign mem_stall = (state_reg == ACCESS) | (state_reg == FAULT) | ((state_reg == IDLE) & access);

  always_comb begin
    wdata_fmt = ex_storeData;
    wstrb_fmt = 4'b1111;
    case (ex_funct3[1:0])
      2'b00: begin
        wdata_fmt = {4{ex_storeData[7:0]}};
        wstrb_fmt = 4'b0001 << ex_addr[1:0];
      end
      2'b01: begin
        wdata_fmt = {2{ex_storeData[15:0]}};
        wstrb_fmt = ex_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
    if (!ex_memWrite) wstrb_fmt = 4'b0000;
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign rbyte[gi] = dmem_rdata[8*gi +: 8];
  end

  // Lane and width come from the request latched at issue, not from EX/MEM.
  always_comb begin
    sel_byte = rbyte[lane_reg];
    sel_half = lane_reg[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (funct3_reg)
      3'b000:  load_fmt = {{24{sel_byte[7]}}, sel_byte};
      3'b001:  load_fmt = {{16{sel_half[15]}}, sel_half};
      3'b100:  load_fmt = {24'd0, sel_byte};
      3'b101:  load_fmt = {16'd0, sel_half};
      default: load_fmt = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      count_reg  <= 8'd0;
      funct3_reg <= 3'b000;
      lane_reg   <= 2'b00;
      load_reg   <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 32'd0;
      dmem_wstrb <= 4'b0000;
      dmem_wdata <= 32'd0;
      readData   <= 32'd0;
      mem_fault  <= 1'b0;
      fault_code <= 2'b00;
      fault_addr <= 32'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (access) begin
            if (op_illegal | misaligned) begin
              state_reg  <= FAULT;
              mem_fault  <= 1'b1;
              fault_code <= op_illegal ? 2'b11 : 2'b01;
              fault_addr <= ex_addr;
            end else begin
              state_reg  <= ACCESS;
              count_reg  <= 8'd0;
              funct3_reg <= ex_funct3;
              lane_reg   <= ex_addr[1:0];
              load_reg   <= ex_memRead;
              dmem_req   <= 1'b1;
              dmem_we    <= ex_memWrite;
              dmem_addr  <= {ex_addr[31:2], 2'b00};
              dmem_wstrb <= wstrb_fmt;
              dmem_wdata <= wdata_fmt;
            end
          end
        end
        ACCESS: begin
          // An ack on the last permitted cycle is checked first so it beats the timeout.
          if (dmem_ack) begin
            state_reg <= DONE;
            dmem_req  <= 1'b0;
            if (load_reg) readData <= load_fmt;
          end else if (count_reg == LAST_WAIT) begin
            state_reg  <= FAULT;
            dmem_req   <= 1'b0;
            mem_fault  <= 1'b1;
            fault_code <= 2'b10;
            fault_addr <= {dmem_addr[31:2], lane_reg};
          end else begin
            count_reg <= count_reg + 8'd1;
          end
        end
        DONE:    state_reg <= IDLE;
        FAULT:   state_reg <= FAULT;
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases followed by random loads/stores
// compared against an arithmetic reference model of lane steering, extension and faults.
module tb_mem_access_unit;

  localparam int T = 16;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic        ex_memRead;
  logic        ex_memWrite;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_addr;
  logic [31:0] ex_storeData;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic [31:0] readData;
  logic        mem_stall;
  logic        mem_fault;
  logic [1:0]  fault_code;
  logic [31:0] fault_addr;

  int          checks = 0;
  int          errors = 0;
  int          txn_id = 0;
  logic [31:0] exp_read;

  logic [2:0]  load_f3_tab [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  logic [2:0]  store_f3_tab [3] = '{3'b000, 3'b001, 3'b010};

  mem_access_unit #(.MEM_TIMEOUT(T)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_memRead(ex_memRead), .ex_memWrite(ex_memWrite),
    .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_storeData(ex_storeData),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wstrb(dmem_wstrb), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .readData(readData), .mem_stall(mem_stall),
    .mem_fault(mem_fault), .fault_code(fault_code), .fault_addr(fault_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // 0 = legal, 1 = misaligned, 3 = illegal operation
  function automatic logic [1:0] model_fault(input logic rd, input logic wr,
                                             input logic [2:0] f3, input logic [31:0] addr);
    int unsigned nbytes;
    if (rd && wr) return 2'd3;
    if (rd && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 2'd3;
    if (wr && !(f3 inside {3'd0, 3'd1, 3'd2})) return 2'd3;
    nbytes = 32'd1 << f3[1:0];
    if ((addr % nbytes) != 0) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rdata);
    longint unsigned nbytes;
    longint unsigned full;
    longint unsigned word;
    longint unsigned v;
    longint          sv;
    nbytes = 64'd1 << f3[1:0];
    if (nbytes == 64'd4) return rdata;
    word = 64'(rdata);
    full = 64'd1 << (8 * nbytes);
    v    = (word >> (8 * (addr % 4))) % full;
    sv   = longint'(v);
    if (!f3[2] && v >= full / 2) sv = sv - longint'(full);
    return sv[31:0];
  endfunction

  task automatic model_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] d,
                             output logic [31:0] wdata, output logic [3:0] wstrb);
    longint unsigned nbytes;
    longint unsigned full;
    longint unsigned dl;
    longint unsigned acc;
    longint unsigned strb;
    nbytes = 64'd1 << f3[1:0];
    full   = 64'd1 << (8 * nbytes);
    dl     = 64'(d);
    acc    = 64'd0;
    for (longint unsigned j = 0; j < 4; j += nbytes) acc += (dl % full) << (8 * j);
    wdata = acc[31:0];
    strb  = ((64'd1 << nbytes) - 64'd1) << (addr % 4);
    wstrb = strb[3:0];
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ex_valid = 1'b0;
    dmem_ack = 1'b0;
    tick();
    rst = 1'b0;
    exp_read = 32'd0;
    check("rst_req", dmem_req, 0);
    check("rst_we", dmem_we, 0);
    check("rst_addr", dmem_addr, 0);
    check("rst_wstrb", dmem_wstrb, 0);
    check("rst_wdata", dmem_wdata, 0);
    check("rst_readdata", readData, 0);
    check("rst_fault", mem_fault, 0);
    check("rst_code", fault_code, 0);
    check("rst_faddr", fault_addr, 0);
    check("rst_stall", mem_stall, 0);
  endtask

  // Presents one instruction in EX/MEM (DUT idle) and plays the memory side; ack_at = ACCESS
  // cycle carrying the ack (0 = never). Faulting transactions end with a reset.
  task automatic run_txn(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [31:0] rdata, input int ack_at);
    logic [1:0]  code;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_wstrb;
    int          stalls;
    txn_id++;
    code = model_fault(rd, wr, f3, addr);
    model_store(f3, addr, sdata, exp_wdata, exp_wstrb);
    ex_valid = 1'b1; ex_memRead = rd; ex_memWrite = wr;
    ex_funct3 = f3; ex_addr = addr; ex_storeData = sdata;
    #1;
    check("stall_present", mem_stall, 1);
    stalls = int'(mem_stall);
    tick();
    if (code != 2'd0) begin
      for (int j = 0; j < 4; j++) begin
        check("illegal_req", dmem_req, 0);
        check("illegal_stall", mem_stall, 1);
        check("illegal_fault", mem_fault, 1);
        check("illegal_code", fault_code, code);
        check("illegal_faddr", fault_addr, addr);
        tick();
      end
      $display("txn %0d rd=%0b wr=%0b f3=%0d addr=%h -> fault code %0d", txn_id, rd, wr, f3, addr, code);
      do_reset();
      return;
    end
    for (int i = 1; i <= T; i++) begin
      check("acc_req", dmem_req, 1);
      check("acc_stall", mem_stall, 1);
      check("acc_addr", dmem_addr, addr - (addr % 4));
      if (i == 1) begin
        check("acc_we", dmem_we, wr);
        check("acc_wstrb", dmem_wstrb, wr ? exp_wstrb : 4'b0000);
        if (wr) check("acc_wdata", dmem_wdata, exp_wdata);
      end
      stalls += int'(mem_stall);
      dmem_rdata = (i == ack_at) ? rdata : $urandom;
      dmem_ack = (i == ack_at);
      tick();
      dmem_ack = 1'b0;
      if (i == ack_at) break;
    end
    if (ack_at == 0) begin
      check("tmo_fault", mem_fault, 1);
      check("tmo_code", fault_code, 2'b10);
      check("tmo_faddr", fault_addr, addr);
      check("tmo_req", dmem_req, 0);
      check("tmo_stall", mem_stall, 1);
      dmem_ack = 1'b1;
      tick();
      dmem_ack = 1'b0;
      check("tmo_sticky", mem_fault, 1);
      check("tmo_sticky_stall", mem_stall, 1);
      $display("txn %0d rd=%0b wr=%0b f3=%0d addr=%h -> timeout", txn_id, rd, wr, f3, addr);
      do_reset();
      return;
    end
    if (rd) exp_read = model_load(f3, addr, rdata);
    check("done_req", dmem_req, 0);
    check("done_stall", mem_stall, 0);
    check("done_fault", mem_fault, 0);
    check("done_readdata", readData, exp_read);
    check("stall_cycles", stalls, ack_at + 1);
    // Stray ack while in DONE must not disturb anything.
    dmem_ack = 1'b1;
    dmem_rdata = ~rdata;
    tick();
    dmem_ack = 1'b0;
    ex_valid = 1'b0;
    #1;
    check("no_reissue", dmem_req, 0);
    check("after_stall", mem_stall, 0);
    check("after_readdata", readData, exp_read);
    $display("txn %0d rd=%0b wr=%0b f3=%0d addr=%h ack_at=%0d readData=%h", txn_id, rd, wr, f3, addr,
             ack_at, readData);
  endtask

  logic        r_rd;
  logic        r_wr;
  logic [2:0]  r_f3;
  logic [31:0] r_addr;
  logic [31:0] r_mask;
  int          r_ack;
  int          r_mode;

  initial begin
    rst = 1'b1;
    ex_valid = 1'b0; ex_memRead = 1'b0; ex_memWrite = 1'b0;
    ex_funct3 = 3'b000; ex_addr = 32'd0; ex_storeData = 32'd0;
    dmem_rdata = 32'd0; dmem_ack = 1'b0;
    exp_read = 32'd0;
    tick();
    do_reset();

    run_txn(1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'd0, 32'h8000_0000, 2);
    check("lb_value", readData, 32'hFFFF_FF80);
    run_txn(1'b1, 1'b0, 3'b100, 32'h0000_1003, 32'd0, 32'h8000_0000, 2);
    check("lbu_value", readData, 32'h0000_0080);
    run_txn(1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 32'hDEAD_BEEF, 1);
    check("sh_readdata_kept", readData, 32'h0000_0080);
    run_txn(1'b1, 1'b0, 3'b010, 32'h0000_1001, 32'd0, 32'd0, 1);
    run_txn(1'b1, 1'b0, 3'b010, 32'h0000_4000, 32'd0, 32'd0, 0);
    run_txn(1'b1, 1'b0, 3'b101, 32'h0000_4006, 32'd0, 32'h8765_4321, T);
    check("ack_last_value", readData, 32'h0000_8765);

    run_txn(1'b1, 1'b0, 3'b010, 32'h0000_5000, 32'd0, 32'hCAFE_F00D, 1);
    run_txn(1'b0, 1'b1, 3'b010, 32'h0000_5004, 32'h0BAD_CAFE, 32'd0, 3);

    // Reset in the third ACCESS cycle, followed by a late ack.
    txn_id++;
    ex_valid = 1'b1; ex_memRead = 1'b1; ex_memWrite = 1'b0;
    ex_funct3 = 3'b010; ex_addr = 32'h0000_3000;
    tick();
    tick();
    tick();
    check("mid_req", dmem_req, 1);
    rst = 1'b1;
    ex_valid = 1'b0;
    tick();
    rst = 1'b0;
    dmem_ack = 1'b1;
    dmem_rdata = 32'h1111_2222;
    check("mid_rst_req", dmem_req, 0);
    check("mid_rst_addr", dmem_addr, 0);
    check("mid_rst_stall", mem_stall, 0);
    tick();
    dmem_ack = 1'b0;
    check("mid_ack_req", dmem_req, 0);
    check("mid_ack_readdata", readData, 0);
    check("mid_ack_fault", mem_fault, 0);
    check("mid_ack_stall", mem_stall, 0);
    exp_read = 32'd0;
    $display("txn %0d reset mid-access then stray ack", txn_id);

    for (int t = 0; t < 40; t++) begin
      r_mode = $urandom_range(0, 19);
      r_rd = (r_mode < 10);
      r_wr = (r_mode == 0) || (r_mode >= 10);
      if (r_rd && !r_wr) r_f3 = load_f3_tab[$urandom_range(0, 4)];
      else r_f3 = store_f3_tab[$urandom_range(0, 2)];
      if ($urandom_range(0, 9) == 0) r_f3 = 3'($urandom_range(0, 7));
      r_addr = $urandom;
      r_mask = (32'd1 << r_f3[1:0]) - 32'd1;
      if ($urandom_range(0, 5) != 0) r_addr = r_addr & ~r_mask;
      r_ack = ($urandom_range(0, 12) == 0) ? 0 : int'($urandom_range(1, 6));
      run_txn(r_rd, r_wr, r_f3, r_addr, $urandom, $urandom, r_ack);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
